program_loader: RTL and testbench
=================================

# program_loader

UART-side program loader of the MIPS top. It consumes received bytes from the UART receiver and recognises the `L` (start) and `E` (end) commands. It packs program bytes big-endian into 32-bit instruction words and writes them sequentially into instruction memory. When loading completes it raises `o_program_loaded` so the pipeline may be released from reset and start fetching.

## Interface
Parameters:
- NB_DATA, 32, instruction word width
- NB_BYTE, 8, UART byte width
- MEM_DEPTH, 64, instruction memory depth in words
- NB_ADDR, $clog2(MEM_DEPTH), word-address width

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  NB_BYTE  byte from UART receiver, valid while i_rx_done=1
- i_rx_done  in  1  one-cycle strobe, new byte available
- o_imem_wr_en  out  1  one-cycle instruction memory write strobe
- o_imem_addr  out  NB_ADDR  word address of current write
- o_imem_wr_data  out  NB_DATA  assembled instruction word
- o_loading  out  1  high while in LOAD state
- o_program_loaded  out  1  high in DONE state
- o_overflow  out  1  sticky, words dropped because memory full
- o_word_count  out  NB_ADDR+1  words written since last `L`

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE: bytes other than `L` (0x4C) are ignored. `L` clears the word count, address, byte index and o_overflow, then moves to LOAD.
  - LOAD: a byte with byte index 0 and value `E` (0x45) moves to DONE. Any other byte shifts into the word shift register, MSB first (`20 01 00 05` yields 0x20010005), and the byte index increments modulo 4.
  - DONE: o_program_loaded=1. `L` restarts exactly as from IDLE. All other bytes are ignored.
- `E` is a command only at a word boundary. A byte 0x45 at index 1..3 is ordinary data. A word whose MSB is 0x45 cannot be loaded; this is a documented restriction, since opcode 0x11 is unused in our ISA.
- `L` inside LOAD is ordinary data at any index.
- Word completion: when the 4th byte arrives (index 3), the loader writes the assembled word at o_imem_addr=o_word_count, then increments o_word_count.
- Memory full: when o_word_count==MEM_DEPTH, a completed word is not written and o_overflow is set. It stays set until the next `L` or reset. The loader remains in LOAD and still honours `E`.
- Words are not zero-extended or modified in any way.

## Timing
- Reset (i_reset=0, asynchronous): state=IDLE and every output is 0. This includes o_imem_wr_en, o_imem_addr, o_imem_wr_data, o_loading, o_program_loaded, o_overflow, o_word_count, plus the byte index and shift register.
- All outputs are registered.
- Byte acceptance: a byte is sampled on the rising edge where i_rx_done=1.
- Write latency: o_imem_wr_en pulses for exactly one cycle on the cycle after the edge that sampled the 4th byte. o_imem_addr and o_imem_wr_data are valid in that same cycle and hold afterwards.
- o_word_count increments on the same edge that raises o_imem_wr_en.
- State outputs follow the state register:
  - o_loading rises 1 cycle after `L` is sampled.
  - o_program_loaded rises 1 cycle after a boundary `E` is sampled, and falls 1 cycle after a restart `L`.
- Back-to-back strobes: the loader accepts i_rx_done on consecutive cycles with no stall. It has no ready/back-pressure output.
- Reset mid-load: the partial word and count are lost, and the loader returns to IDLE.
- Deassertion of reset takes effect at the next clock edge.

## Test plan
- Normal load:
  - Stimulus: `L`, then bytes 20 01 00 05 20 02 00 00, then `E`.
  - Response: two write pulses, addr0=0x20010005 and addr1=0x20020000. o_word_count=2, o_program_loaded=1, o_loading=0.
- Embedded 0x45:
  - Stimulus: `L`, then 20 07 00 45, then `E`.
  - Response: one write, addr0=0x20070045. DONE is entered only on the final `E`.
- Idle garbage:
  - Stimulus: 0x20, 0x45, 0x00 before any `L`.
  - Response: no writes, outputs stay at reset values. A following `L` 40 00 00 00 `E` writes addr0=0x40000000.
- Overflow:
  - Setup: MEM_DEPTH=4.
  - Stimulus: `L`, then 5 full words, then `E`.
  - Response: 4 writes at addr 0..3, o_overflow=1 after the 5th word, o_word_count=4, o_program_loaded=1.
- Reload from DONE:
  - Stimulus: after a 2-word load, send `L` F4 00 00 00 `E`.
  - Response: o_program_loaded drops then rises. One write at addr0=0xF4000000, o_word_count=1, o_overflow=0.
- Reset mid-load:
  - Stimulus: `L` 20 01, assert i_reset=0 for 3 cycles, release, then `L` 00 61 28 2A `E`.
  - Response: all outputs return to 0 asynchronously. Afterwards a single write at addr0=0x0061282A.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: UART-side program loader.
// Watches received UART bytes for the 'L' (start) and 'E' (end) commands.
// Between them it packs bytes big-endian into instruction words and writes
// them to consecutive instruction-memory addresses. It raises
// o_program_loaded once the program is in memory.
//
// Ports:
//   i_clock           system clock
//   i_reset           asynchronous active-low reset
//   i_rx_data         received byte, valid while i_rx_done=1
//   i_rx_done         one-cycle strobe, new byte available
//   o_imem_wr_en      one-cycle instruction memory write strobe
//   o_imem_addr       word address of the current write
//   o_imem_wr_data    assembled instruction word
//   o_loading         high while in LOAD
//   o_program_loaded  high while in DONE
//   o_overflow        sticky, a completed word was dropped because memory is full
//   o_word_count      words written since the last 'L'
module program_loader #(
  parameter int NB_DATA   = 32,
  parameter int NB_BYTE   = 8,
  parameter int MEM_DEPTH = 64,
  parameter int NB_ADDR   = $clog2(MEM_DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_imem_wr_en,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_wr_data,
  output logic               o_loading,
  output logic               o_program_loaded,
  output logic               o_overflow,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam int unsigned NB_SHIFT = NB_DATA - NB_BYTE;
  localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_E = NB_BYTE'(8'h45);
  localparam logic [NB_ADDR:0]   FULL  = (NB_ADDR+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          byte_idx;
  // Only the three leading bytes need storing; the fourth arrives on i_rx_data.
  logic [NB_SHIFT-1:0] shift_reg;
  logic [NB_DATA-1:0]  next_word;

  assign next_word = {shift_reg, i_rx_data};

  // Loader state machine with registered outputs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= ST_IDLE;
      byte_idx         <= 2'd0;
      shift_reg        <= '0;
      o_imem_wr_en     <= 1'b0;
      o_imem_addr      <= '0;
      o_imem_wr_data   <= '0;
      o_loading        <= 1'b0;
      o_program_loaded <= 1'b0;
      o_overflow       <= 1'b0;
      o_word_count     <= '0;
    end else begin
      o_imem_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          // 'L' starts a fresh load from either idle or done.
          if (i_rx_done && (i_rx_data == CMD_L)) begin
            state            <= ST_LOAD;
            o_loading        <= 1'b1;
            o_program_loaded <= 1'b0;
            o_word_count     <= '0;
            o_imem_addr      <= '0;
            byte_idx         <= 2'd0;
            shift_reg        <= '0;
            o_overflow       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (i_rx_done) begin
            // 'E' is a command only at a word boundary; elsewhere it is data.
            if ((byte_idx == 2'd0) && (i_rx_data == CMD_E)) begin
              state            <= ST_DONE;
              o_loading        <= 1'b0;
              o_program_loaded <= 1'b1;
            end else begin
              shift_reg <= next_word[NB_SHIFT-1:0];
              byte_idx  <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                if (o_word_count != FULL) begin
                  o_imem_wr_en   <= 1'b1;
                  o_imem_addr    <= o_word_count[NB_ADDR-1:0];
                  o_imem_wr_data <= next_word;
                  o_word_count   <= o_word_count + (NB_ADDR+1)'(1);
                end else begin
                  o_overflow <= 1'b1;
                end
              end
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          o_loading <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader, built with MEM_DEPTH=4 so the
// memory-full path is reachable with a short stimulus.
module tb_program_loader;

  localparam int NB_DATA   = 32;
  localparam int NB_BYTE   = 8;
  localparam int MEM_DEPTH = 4;
  localparam int NB_ADDR   = 2;

  logic               clk;
  logic               rst_n;
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_done;
  logic               wr_en;
  logic [NB_ADDR-1:0] addr;
  logic [NB_DATA-1:0] wr_data;
  logic               loading;
  logic               loaded;
  logic               overflow;
  logic [NB_ADDR:0]   word_count;

  int vectors;
  int miscompares;

  logic [NB_DATA-1:0] wd_q[$];
  logic [NB_ADDR-1:0] wa_q[$];

  program_loader #(
    .NB_DATA  (NB_DATA),
    .NB_BYTE  (NB_BYTE),
    .MEM_DEPTH(MEM_DEPTH),
    .NB_ADDR  (NB_ADDR)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_rx_data       (rx_data),
    .i_rx_done       (rx_done),
    .o_imem_wr_en    (wr_en),
    .o_imem_addr     (addr),
    .o_imem_wr_data  (wr_data),
    .o_loading       (loading),
    .o_program_loaded(loaded),
    .o_overflow      (overflow),
    .o_word_count    (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wd_q.push_back(wr_data);
      wa_q.push_back(addr);
    end
  end

  // Present one byte for exactly one rising edge; consecutive calls are back-to-back.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_done = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    vectors++; if (addr !== 2'd0) begin miscompares++; $display("FAIL reset_addr got %h exp 0", addr); end
    vectors++; if (wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL reset_loading got %b exp 0", loading); end
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL reset_loaded got %b exp 0", loaded); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_idle_garbage;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h20); send_byte(8'h45); send_byte(8'h00);
    idle(2);
    vectors++; if (wd_q.size() !== 0) begin miscompares++; $display("FAIL garbage_writes got %0d exp 0", wd_q.size()); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL garbage_loading got %b exp 0", loading); end
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL garbage_loaded got %b exp 0", loaded); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL garbage_count got %0d exp 0", word_count); end
    vectors++; if (wr_data !== 32'h0) begin miscompares++; $display("FAIL garbage_wr_data got %h exp 0", wr_data); end
    send_byte(8'h4C); send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h45);
    idle(2);
    vectors++; if (wd_q.size() !== 1) begin miscompares++; $display("FAIL garbage_load_writes got %0d exp 1", wd_q.size()); end
    else begin
      vectors++; if (wd_q[0] !== 32'h40000000) begin miscompares++; $display("FAIL garbage_load_data got %h exp 40000000", wd_q[0]); end
      vectors++; if (wa_q[0] !== 2'd0) begin miscompares++; $display("FAIL garbage_load_addr got %0d exp 0", wa_q[0]); end
    end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL garbage_load_done got %b exp 1", loaded); end
  endtask

  task automatic test_normal_load;
    logic [31:0] exp_d[2];
    exp_d[0] = 32'h20010005;
    exp_d[1] = 32'h20020000;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h4C);
    send_byte(8'h20);
    // 'L' has now been sampled one cycle ago.
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL normal_loading_rise got %b exp 1", loading); end
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL normal_loaded_fall got %b exp 0", loaded); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL normal_count_clear got %0d exp 0", word_count); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h45);
    idle(2);
    vectors++; if (wd_q.size() !== 2) begin miscompares++; $display("FAIL normal_writes got %0d exp 2", wd_q.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        vectors++; if (wd_q[i] !== exp_d[i]) begin miscompares++; $display("FAIL normal_data[%0d] got %h exp %h", i, wd_q[i], exp_d[i]); end
        vectors++; if (wa_q[i] !== 2'(i)) begin miscompares++; $display("FAIL normal_addr[%0d] got %0d exp %0d", i, wa_q[i], i); end
      end
    end
    vectors++; if (word_count !== 3'd2) begin miscompares++; $display("FAIL normal_count got %0d exp 2", word_count); end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL normal_loaded got %b exp 1", loaded); end
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL normal_loading got %b exp 0", loading); end
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL normal_wr_en_idle got %b exp 0", wr_en); end
  endtask

  task automatic test_embedded_45;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h4C);
    send_byte(8'h20); send_byte(8'h07); send_byte(8'h00); send_byte(8'h45);
    idle(2);
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL embed_early_done got %b exp 0", loaded); end
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL embed_loading got %b exp 1", loading); end
    send_byte(8'h45);
    idle(2);
    vectors++; if (wd_q.size() !== 1) begin miscompares++; $display("FAIL embed_writes got %0d exp 1", wd_q.size()); end
    else begin
      vectors++; if (wd_q[0] !== 32'h20070045) begin miscompares++; $display("FAIL embed_data got %h exp 20070045", wd_q[0]); end
    end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL embed_done got %b exp 1", loaded); end
    vectors++; if (word_count !== 3'd1) begin miscompares++; $display("FAIL embed_count got %0d exp 1", word_count); end
  endtask

  task automatic test_overflow;
    logic [31:0] w;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h4C);
    for (int k = 0; k < 5; k++) begin
      w = 32'h01020304 + 32'(k) * 32'h10101010;
      for (int b = 3; b >= 0; b--) begin
        send_byte(w[b*8 +: 8]);
        if (k == 4 && b == 3) begin
          vectors++; if (word_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count_full got %0d exp 4", word_count); end
          vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early got %b exp 0", overflow); end
        end
      end
    end
    send_byte(8'h45);
    // Fifth word has been dropped; 'E' not yet sampled, still loading.
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    vectors++; if (loading !== 1'b1) begin miscompares++; $display("FAIL ovf_still_loading got %b exp 1", loading); end
    idle(2);
    vectors++; if (wd_q.size() !== 4) begin miscompares++; $display("FAIL ovf_writes got %0d exp 4", wd_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        w = 32'h01020304 + 32'(i) * 32'h10101010;
        vectors++; if (wd_q[i] !== w) begin miscompares++; $display("FAIL ovf_data[%0d] got %h exp %h", i, wd_q[i], w); end
        vectors++; if (wa_q[i] !== 2'(i)) begin miscompares++; $display("FAIL ovf_addr[%0d] got %0d exp %0d", i, wa_q[i], i); end
      end
    end
    vectors++; if (word_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count got %0d exp 4", word_count); end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL ovf_done got %b exp 1", loaded); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_reload;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h4C);
    idle(1);
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL reload_loaded_fall got %b exp 0", loaded); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reload_ovf_clear got %b exp 0", overflow); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL reload_count_clear got %0d exp 0", word_count); end
    send_byte(8'hF4); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h45);
    idle(2);
    vectors++; if (wd_q.size() !== 1) begin miscompares++; $display("FAIL reload_writes got %0d exp 1", wd_q.size()); end
    else begin
      vectors++; if (wd_q[0] !== 32'hF4000000) begin miscompares++; $display("FAIL reload_data got %h exp F4000000", wd_q[0]); end
      vectors++; if (wa_q[0] !== 2'd0) begin miscompares++; $display("FAIL reload_addr got %0d exp 0", wa_q[0]); end
    end
    vectors++; if (word_count !== 3'd1) begin miscompares++; $display("FAIL reload_count got %0d exp 1", word_count); end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL reload_done got %b exp 1", loaded); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reload_ovf got %b exp 0", overflow); end
  endtask

  task automatic test_reset_mid_load;
    send_byte(8'h4C); send_byte(8'h20); send_byte(8'h01);
    idle(1);
    // Assert reset between clock edges to exercise the asynchronous path.
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (loading !== 1'b0) begin miscompares++; $display("FAIL midrst_loading got %b exp 0", loading); end
    vectors++; if (wr_data !== 32'h0) begin miscompares++; $display("FAIL midrst_wr_data got %h exp 0", wr_data); end
    vectors++; if (word_count !== 3'd0) begin miscompares++; $display("FAIL midrst_count got %0d exp 0", word_count); end
    vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL midrst_loaded got %b exp 0", loaded); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wd_q.delete(); wa_q.delete();
    send_byte(8'h4C);
    send_byte(8'h00); send_byte(8'h61); send_byte(8'h28); send_byte(8'h2A);
    send_byte(8'h45);
    idle(2);
    vectors++; if (wd_q.size() !== 1) begin miscompares++; $display("FAIL midrst_writes got %0d exp 1", wd_q.size()); end
    else begin
      vectors++; if (wd_q[0] !== 32'h0061282A) begin miscompares++; $display("FAIL midrst_data got %h exp 0061282A", wd_q[0]); end
      vectors++; if (wa_q[0] !== 2'd0) begin miscompares++; $display("FAIL midrst_addr got %0d exp 0", wa_q[0]); end
    end
    vectors++; if (word_count !== 3'd1) begin miscompares++; $display("FAIL midrst_count_final got %0d exp 1", word_count); end
    vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL midrst_done got %b exp 1", loaded); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rx_done     = 1'b0;
    rx_data     = 8'h00;
    test_reset();
    test_idle_garbage();
    test_normal_load();
    test_embedded_45();
    test_overflow();
    test_reload();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
